// File: rtl/norm_shift_pipe_pkg.sv
// Shared widths and stage payload types for the normalizer pipeline.
// Payload structs are sized by the package defaults; top-level WIDTH/EXP_W must match them.
package norm_pkg;

  localparam int NORM_WIDTH = 16;
  localparam int NORM_EXP_W = 8;
  localparam int NORM_COUNT = $clog2(NORM_WIDTH);

  typedef struct packed {
    logic [NORM_WIDTH-1:0] data;
    logic [NORM_COUNT-1:0] shift;
    logic [NORM_EXP_W-1:0] exp_n;
    logic                  zero;
    logic                  uflow;
    logic                  err;
  } s1_payload_t;

  typedef struct packed {
    logic [NORM_WIDTH-1:0] data;
    logic [NORM_EXP_W-1:0] exp;
    logic                  zero;
    logic                  uflow;
    logic                  err;
  } s2_payload_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/norm_shift_pipe_if.sv
// Valid/ready bus of the normalizer: upstream LZC results in, normalized mantissa out.
// slave = the normalizer, master = the surrounding logic driving/consuming it.
interface norm_shift_pipe_if
  import norm_pkg::*;
#(
  parameter int WIDTH = NORM_WIDTH,
  parameter int EXP_W = NORM_EXP_W
);
  localparam int COUNT = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [COUNT:0]   in_zcnt;
  logic             in_nz;
  logic [EXP_W-1:0] in_exp;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [EXP_W-1:0] out_exp;
  logic             out_zero;
  logic             out_uflow;
  logic             out_err;

  modport slave (
    input  in_valid, in_data, in_zcnt, in_nz, in_exp, out_ready,
    output in_ready, out_valid, out_data, out_exp, out_zero, out_uflow, out_err
  );

  modport master (
    output in_valid, in_data, in_zcnt, in_nz, in_exp, out_ready,
    input  in_ready, out_valid, out_data, out_exp, out_zero, out_uflow, out_err
  );

endinterface

// File: rtl/norm_barrel_shl.sv
// Logarithmic left shifter with zero fill: one 2:1 mux level per shift-amount bit.
module norm_barrel_shl #(
  parameter  int WIDTH = 16,
  localparam int COUNT = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic [COUNT-1:0] shift_i,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] lvl [COUNT+1];

  assign lvl[0] = data_i;

  for (genvar i = 0; i < COUNT; i++) begin : g_lvl
    assign lvl[i+1] = shift_i[i] ? (lvl[i] << (1 << i)) : lvl[i];
  end

  assign data_o = lvl[COUNT];

endmodule

// File: rtl/norm_shift_pipe.sv
// Two-stage normalizer: S1 decides shift/exponent/underflow, S2 applies the barrel shift.
// Optional consistency checker on the incoming LZC result: define NORM_SHIFT_CHECK_EN.
module norm_shift_pipe
  import norm_pkg::*;
#(
  parameter int WIDTH = NORM_WIDTH,
  parameter int EXP_W = NORM_EXP_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  norm_shift_pipe_if.slave      bus
);

  localparam int COUNT = $clog2(WIDTH);
  localparam int CMP_W = max_int(EXP_W, COUNT + 1);

  logic        s1_valid_q, s1_valid_d;
  logic        s2_valid_q, s2_valid_d;
  logic        rdy_en_q;
  s1_payload_t s1_q, s1_d;
  s2_payload_t s2_q, s2_d;

  logic             s1_load;
  logic             s2_load;
  logic             in_xfer;
  logic             chk_err;
  logic [CMP_W-1:0] zcnt_ext;
  logic [CMP_W-1:0] exp_ext;
  logic [WIDTH-1:0] shl_data;

  assign s2_load      = !s2_valid_q || bus.out_ready;
  assign s1_load      = !s1_valid_q || s2_load;
  // rdy_en_q keeps in_ready low until the first edge after reset release
  assign bus.in_ready = rdy_en_q && s1_load;
  assign in_xfer      = bus.in_valid && bus.in_ready;

  assign zcnt_ext = CMP_W'(bus.in_zcnt);
  assign exp_ext  = CMP_W'(bus.in_exp);

`ifdef NORM_SHIFT_CHECK_EN
  logic [COUNT:0] lzc;

  always_comb begin
    lzc = (COUNT+1)'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (bus.in_data[i]) lzc = (COUNT+1)'(WIDTH - 1 - i);
    end
  end

  assign chk_err = (lzc != bus.in_zcnt) || ((bus.in_data != '0) != bus.in_nz);
`else
  assign chk_err = 1'b0;
`endif

  always_comb begin
    s1_d      = '0;
    s1_d.data = bus.in_data;
    s1_d.err  = chk_err;
    if (!bus.in_nz) begin
      s1_d.zero = 1'b1;
    end else if (zcnt_ext <= exp_ext) begin
      s1_d.shift = bus.in_zcnt[COUNT-1:0];
      s1_d.exp_n = EXP_W'(exp_ext - zcnt_ext);
    end else begin
      // exponent is below WIDTH here, so it fits the shift field
      s1_d.shift = exp_ext[COUNT-1:0];
      s1_d.uflow = 1'b1;
    end
  end

  norm_barrel_shl #(.WIDTH(WIDTH)) u_shl (
    .data_i  (s1_q.data),
    .shift_i (s1_q.shift),
    .data_o  (shl_data)
  );

  always_comb begin
    s2_d       = '0;
    s2_d.data  = shl_data;
    s2_d.exp   = s1_q.exp_n;
    s2_d.zero  = s1_q.zero;
    s2_d.uflow = s1_q.uflow;
    s2_d.err   = s1_q.err;
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    if (s1_load) s1_valid_d = in_xfer;
    if (s2_load) s2_valid_d = s1_valid_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      rdy_en_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      rdy_en_q   <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      if (in_xfer) s1_q <= s1_d;
      if (s2_load && s1_valid_q) s2_q <= s2_d;
    end
  end

  assign bus.out_valid = s2_valid_q;
  assign bus.out_data  = s2_q.data;
  assign bus.out_exp   = s2_q.exp;
  assign bus.out_zero  = s2_q.zero;
  assign bus.out_uflow = s2_q.uflow;
  assign bus.out_err   = s2_q.err;

endmodule

// File: tb/tb_norm_shift_pipe.sv
// Self-checking bench for norm_shift_pipe: directed cases, stall/reset scenarios, random traffic vs. a reference model.
module tb_norm_shift_pipe;
  import norm_pkg::*;

  localparam int WIDTH = 16;
  localparam int EXP_W = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  norm_shift_pipe_if #(.WIDTH(WIDTH), .EXP_W(EXP_W)) bus ();

  norm_shift_pipe #(.WIDTH(WIDTH), .EXP_W(EXP_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [15:0] data;
    logic [7:0]  expo;
    logic        zero;
    logic        uflow;
    logic        err;
  } res_t;

  res_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, expv, $time);
    end
  endtask

  function automatic res_t ref_norm(input logic [15:0] d, input logic [4:0] z,
                                    input logic nz, input logic [7:0] e);
    res_t r;
    int   lz;
    lz = 16;
    for (int i = 15; i >= 0; i--) begin
      if (d[i]) begin
        lz = 15 - i;
        break;
      end
    end
    r.err = 1'b0;
`ifdef NORM_SHIFT_CHECK_EN
    r.err = (lz != int'(z)) || ((d != 16'h0) != nz);
`endif
    r.zero  = 1'b0;
    r.uflow = 1'b0;
    if (!nz) begin
      r.data = d;
      r.expo = 8'h0;
      r.zero = 1'b1;
    end else if (int'(z) <= int'(e)) begin
      r.data = d << z;
      r.expo = 8'(int'(e) - int'(z));
    end else begin
      r.data  = d << e;
      r.expo  = 8'h0;
      r.uflow = 1'b1;
    end
    return r;
  endfunction

  // scoreboard and output-hold monitor
  logic stall_prev = 1'b0;
  res_t stall_val;
  res_t cur;
  res_t e_pop;

  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      cur.data  = bus.out_data;
      cur.expo  = bus.out_exp;
      cur.zero  = bus.out_zero;
      cur.uflow = bus.out_uflow;
      cur.err   = bus.out_err;
      if (stall_prev) begin
        check_val("hold_valid", 32'(bus.out_valid), 32'd1);
        check_val("hold_data", 32'(cur.data), 32'(stall_val.data));
        check_val("hold_exp", 32'(cur.expo), 32'(stall_val.expo));
        check_val("hold_flags", {29'd0, cur.zero, cur.uflow, cur.err},
                  {29'd0, stall_val.zero, stall_val.uflow, stall_val.err});
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check_val("unexpected_out", 32'd1, 32'd0);
        end else begin
          e_pop = exp_q.pop_front();
          check_val("out_data", 32'(cur.data), 32'(e_pop.data));
          check_val("out_exp", 32'(cur.expo), 32'(e_pop.expo));
          check_val("out_zero", 32'(cur.zero), 32'(e_pop.zero));
          check_val("out_uflow", 32'(cur.uflow), 32'(e_pop.uflow));
          check_val("out_err", 32'(cur.err), 32'(e_pop.err));
        end
      end
      if (bus.in_valid && bus.in_ready)
        exp_q.push_back(ref_norm(bus.in_data, bus.in_zcnt, bus.in_nz, bus.in_exp));
      stall_prev = bus.out_valid && !bus.out_ready;
      stall_val  = cur;
    end
  end

  task automatic drive(input logic [15:0] d, input logic [4:0] z, input logic nz, input logic [7:0] e);
    bus.in_data  = d;
    bus.in_zcnt  = z;
    bus.in_nz    = nz;
    bus.in_exp   = e;
    bus.in_valid = 1'b1;
  endtask

  task automatic gen_drive();
    logic [15:0] top, mask, d;
    logic [4:0]  z;
    logic        nz;
    logic [7:0]  e;
    int          r, lz;
    r = $urandom_range(0, 9);
    if (r == 0) begin
      d  = 16'h0;
      z  = 5'd16;
      nz = 1'b0;
    end else begin
      lz   = $urandom_range(0, 15);
      top  = 16'h8000 >> lz;
      mask = top - 16'h1;
      d    = top | (16'($urandom) & mask);
      z    = 5'(lz);
      nz   = 1'b1;
      if (r == 1) z = 5'($urandom_range(0, 15));
    end
    e = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 30));
    drive(d, z, nz, e);
  endtask

  task automatic directed(input string tag, input logic [15:0] d, input logic [4:0] z, input logic nz,
                          input logic [7:0] e, input logic [15:0] ed, input logic [7:0] ee,
                          input logic ez, input logic eu, input logic eerr);
    drive(d, z, nz, e);
    check_val({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check_val({tag, "_lat1"}, 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;
    check_val({tag, "_lat2"}, 32'(bus.out_valid), 32'd1);
    check_val({tag, "_data"}, 32'(bus.out_data), 32'(ed));
    check_val({tag, "_exp"}, 32'(bus.out_exp), 32'(ee));
    check_val({tag, "_flags"}, {29'd0, bus.out_zero, bus.out_uflow, bus.out_err}, {29'd0, ez, eu, eerr});
    @(posedge clk); #1;
  endtask

  logic exp_err_d4;
  int   acc;
  logic took;
  int   waited;

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_zcnt   = '0;
    bus.in_nz     = 1'b0;
    bus.in_exp    = '0;
    bus.out_ready = 1'b1;
`ifdef NORM_SHIFT_CHECK_EN
    exp_err_d4 = 1'b1;
`else
    exp_err_d4 = 1'b0;
`endif

    #2;
    check_val("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_val("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check_val("rst_out_data", 32'(bus.out_data), 32'd0);
    check_val("rst_out_exp", 32'(bus.out_exp), 32'd0);
    check_val("rst_flags", {29'd0, bus.out_zero, bus.out_uflow, bus.out_err}, 32'd0);
    #10 rst_n = 1'b1;
    #1 check_val("rel_in_ready0", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    check_val("rel_in_ready1", 32'(bus.in_ready), 32'd1);

    directed("norm", 16'h0010, 5'd11, 1'b1, 8'd20, 16'h8000, 8'd9, 1'b0, 1'b0, 1'b0);
    directed("uflow", 16'h0010, 5'd11, 1'b1, 8'd5, 16'h0200, 8'd0, 1'b0, 1'b1, 1'b0);
    directed("zero", 16'h0000, 5'd16, 1'b0, 8'd77, 16'h0000, 8'd0, 1'b1, 1'b0, 1'b0);
    directed("badz", 16'h0010, 5'd3, 1'b1, 8'd20, 16'h0080, 8'd17, 1'b0, 1'b0, exp_err_d4);

    // four back-to-back transfers, results on four consecutive cycles
    gen_drive();
    @(posedge clk); #1;
    gen_drive();
    @(posedge clk); #1;
    check_val("b2b_v0", 32'(bus.out_valid), 32'd1);
    gen_drive();
    @(posedge clk); #1;
    check_val("b2b_v1", 32'(bus.out_valid), 32'd1);
    gen_drive();
    @(posedge clk); #1;
    check_val("b2b_v2", 32'(bus.out_valid), 32'd1);
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    check_val("b2b_v3", 32'(bus.out_valid), 32'd1);
    @(posedge clk); #1;
    check_val("b2b_empty", 32'(bus.out_valid), 32'd0);

    // stall: only two entries fit
    bus.out_ready = 1'b0;
    acc = 0;
    for (int k = 0; k < 3; k++) begin
      gen_drive();
      #3;
      if (bus.in_ready) acc++;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    check_val("stall_accepts", 32'(acc), 32'd2);
    check_val("stall_in_ready", 32'(bus.in_ready), 32'd0);
    check_val("stall_out_valid", 32'(bus.out_valid), 32'd1);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_val("stall_drained", 32'(exp_q.size()), 32'd0);

    // reset with both stages full
    bus.out_ready = 1'b0;
    gen_drive();
    @(posedge clk); #1;
    gen_drive();
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check_val("full_before_rst", 32'(bus.out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_val("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_val("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
    check_val("mid_rst_out_data", 32'(bus.out_data), 32'd0);
    exp_q.delete();
    @(posedge clk); #2;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    #1 check_val("mid_rel_in_ready0", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    check_val("mid_rel_in_ready1", 32'(bus.in_ready), 32'd1);
    for (int k = 0; k < 3; k++) begin
      check_val("no_stale", 32'(bus.out_valid), 32'd0);
      @(posedge clk); #1;
    end

    // random traffic with random backpressure
    took = 1'b1;
    for (int c = 0; c < 400; c++) begin
      if (!bus.in_valid || took) begin
        if ($urandom_range(0, 9) < 7) gen_drive();
        else bus.in_valid = 1'b0;
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      #3;
      took = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    waited = 0;
    while (exp_q.size() != 0 && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    check_val("rand_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
